// File: rtl/m_dm_ctrl_pkg.sv
// m_dm_ctrl_pkg: shared size codes, FSM state encodings and address-map defaults
package m_dm_ctrl_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;
  localparam logic [31:0] DM_LO_DEF  = 32'h0000_0000;
  localparam logic [31:0] DM_HI_DEF  = 32'h0000_2FFF;
  localparam logic [31:0] DEV_LO_DEF = 32'h0000_7F00;
  localparam logic [31:0] DEV_HI_DEF = 32'h0000_7F1B;
endpackage

// File: rtl/m_dm_ctrl_ext.sv
// dm_ext: load lane select plus sign/zero extension
//   rdata : memory read word
//   lo    : byte offset addr[1:0]
//   size  : access size (size[1] set means word)
//   uns   : zero-extend when set
//   res   : extended 32-bit load result
module dm_ext
  import m_dm_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] res
);
  logic [31:0] sh;
  assign sh  = rdata >> {lo, 3'b000};
  assign res = size[1]          ? sh :
               size == SZ_HALF  ? {{16{~uns & sh[15]}}, sh[15:0]} :
                                  {{24{~uns & sh[7]}}, sh[7:0]};
endmodule

// File: rtl/m_dm_ctrl.sv
// m_dm_ctrl: M-stage data-memory access controller (req/ack bus, byte lanes, load extension, AdEL/AdES, stall)
//   clk, reset(active-low async)
//   m_load/m_store/m_size/m_unsigned/m_addr/m_wdata : M-stage access control
//   Req                : CP0 flush
//   bus_*              : request/acknowledge bus toward data RAM and devices
//   M_DMRD             : extended load result, held until the next completed load
//   mem_stall          : freeze IF..M while a transaction is outstanding
//   exc_adel/exc_ades  : combinational address exceptions
module m_dm_ctrl
  import m_dm_ctrl_pkg::*;
#(
  parameter logic [31:0] DM_LO  = DM_LO_DEF,
  parameter logic [31:0] DM_HI  = DM_HI_DEF,
  parameter logic [31:0] DEV_LO = DEV_LO_DEF,
  parameter logic [31:0] DEV_HI = DEV_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_load,
  input  logic        m_store,
  input  logic [1:0]  m_size,
  input  logic        m_unsigned,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        Req,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [31:0] M_DMRD,
  output logic        mem_stall,
  output logic        exc_adel,
  output logic        exc_ades
);
  logic [1:0]  st, ld_sz, ld_lo;
  logic        ld, ld_uns;
  logic        is_word, is_half, misal, in_dm, in_dev, exc, acc, start;
  logic [3:0]  be;
  logic [31:0] wd, ext;
  assign is_word = m_size[1];
  assign is_half = m_size == SZ_HALF;
  assign misal   = is_word ? |m_addr[1:0] : is_half & m_addr[0];
  // offset-and-compare range checks stay correct when a lower bound is zero
  assign in_dm   = (m_addr - DM_LO) <= (DM_HI - DM_LO);
  assign in_dev  = (m_addr - DEV_LO) <= (DEV_HI - DEV_LO);
  assign exc     = misal | ~(in_dm | in_dev) | (in_dev & ~is_word);
  assign acc     = m_load | m_store;
  assign start   = acc & ~exc & ~Req;
  assign exc_adel = m_load & exc;
  assign exc_ades = m_store & exc;
  assign be = is_word ? 4'hF : (is_half ? 4'b0011 : 4'b0001) << m_addr[1:0];
  assign wd = is_word ? m_wdata : is_half ? {2{m_wdata[15:0]}} : {4{m_wdata[7:0]}};
  // a flushed instruction's successor keeps stalling until the drained access retires
  assign mem_stall = ((st == ST_IDLE) & start) | (st == ST_WAIT) | ((st == ST_DRAIN) & acc);
  dm_ext u_ext (.rdata(bus_rdata), .lo(ld_lo), .size(ld_sz), .uns(ld_uns), .res(ext));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= ST_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'h0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      M_DMRD    <= 32'h0;
      ld        <= 1'b0;
      ld_sz     <= 2'd0;
      ld_lo     <= 2'd0;
      ld_uns    <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: if (start) begin
          bus_req   <= 1'b1;
          bus_we    <= m_store;
          bus_be    <= be;
          bus_addr  <= {m_addr[31:2], 2'b00};
          bus_wdata <= wd;
          ld        <= m_load;
          ld_sz     <= m_size;
          ld_lo     <= m_addr[1:0];
          ld_uns    <= m_unsigned;
          st        <= ST_WAIT;
        end
        ST_WAIT: if (bus_ack) begin
          bus_req <= 1'b0;
          if (!Req && ld) M_DMRD <= ext;
          st <= Req ? ST_IDLE : ST_DONE;
        end else if (Req) st <= ST_DRAIN;
        ST_DONE: st <= ST_IDLE;
        default: if (bus_ack) begin
          bus_req <= 1'b0;
          st      <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_m_dm_ctrl.sv
// tb_m_dm_ctrl: table-driven and directed checks of the M-stage data-memory controller
module tb_m_dm_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        m_load = 1'b0, m_store = 1'b0, m_unsigned = 1'b0, Req = 1'b0, bus_ack = 1'b0;
  logic [1:0]  m_size = 2'd0;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, bus_rdata = 32'h0;
  logic        bus_req, bus_we, mem_stall, exc_adel, exc_ades;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata, M_DMRD;
  int total = 0, bad = 0, cnt;
  typedef struct {
    logic ld, st; logic [1:0] sz; logic uns;
    logic [31:0] addr, wdata, rdata;
    logic adel, ades; logic [3:0] be;
    logic [31:0] bwd, baddr, dmrd;
  } vec_t;
  vec_t v[16];
  m_dm_ctrl dut (
    .clk(clk), .reset(reset), .m_load(m_load), .m_store(m_store), .m_size(m_size),
    .m_unsigned(m_unsigned), .m_addr(m_addr), .m_wdata(m_wdata), .Req(Req),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .M_DMRD(M_DMRD),
    .mem_stall(mem_stall), .exc_adel(exc_adel), .exc_ades(exc_ades)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask
  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    m_load = ld; m_store = st; m_size = sz; m_unsigned = uns; m_addr = a; m_wdata = wd;
  endtask
  task automatic idle_in();
    m_load = 1'b0; m_store = 1'b0;
  endtask
  initial begin
    v[0]  = '{1'b1,1'b0,2'd2,1'b0,32'h10,  32'h0,       32'hDEADBEEF,1'b0,1'b0,4'hF,32'h0,       32'h10,  32'hDEADBEEF};
    v[1]  = '{1'b1,1'b0,2'd0,1'b0,32'h13,  32'h0,       32'h80AABBCC,1'b0,1'b0,4'h8,32'h0,       32'h10,  32'hFFFFFF80};
    v[2]  = '{1'b1,1'b0,2'd0,1'b1,32'h13,  32'h0,       32'h80AABBCC,1'b0,1'b0,4'h8,32'h0,       32'h10,  32'h00000080};
    v[3]  = '{1'b0,1'b1,2'd1,1'b0,32'h22,  32'h1234,    32'h0,       1'b0,1'b0,4'hC,32'h12341234,32'h20,  32'h00000080};
    v[4]  = '{1'b1,1'b0,2'd1,1'b0,32'h11,  32'h0,       32'h0,       1'b1,1'b0,4'h0,32'h0,       32'h0,   32'h00000080};
    v[5]  = '{1'b0,1'b1,2'd0,1'b0,32'h7F04,32'h0,       32'h0,       1'b0,1'b1,4'h0,32'h0,       32'h0,   32'h00000080};
    v[6]  = '{1'b0,1'b1,2'd2,1'b0,32'h5000,32'h0,       32'h0,       1'b0,1'b1,4'h0,32'h0,       32'h0,   32'h00000080};
    v[7]  = '{1'b1,1'b0,2'd1,1'b1,32'h2FFE,32'h0,       32'hFFEE1122,1'b0,1'b0,4'hC,32'h0,       32'h2FFC,32'h0000FFEE};
    v[8]  = '{1'b1,1'b0,2'd1,1'b0,32'h2FFE,32'h0,       32'hFFEE1122,1'b0,1'b0,4'hC,32'h0,       32'h2FFC,32'hFFFFFFEE};
    v[9]  = '{1'b1,1'b0,2'd2,1'b0,32'h7F18,32'h0,       32'h12345678,1'b0,1'b0,4'hF,32'h0,       32'h7F18,32'h12345678};
    v[10] = '{1'b1,1'b0,2'd2,1'b0,32'h7F1C,32'h0,       32'h0,       1'b1,1'b0,4'h0,32'h0,       32'h0,   32'h12345678};
    v[11] = '{1'b0,1'b1,2'd0,1'b0,32'h3000,32'h0,       32'h0,       1'b0,1'b1,4'h0,32'h0,       32'h0,   32'h12345678};
    v[12] = '{1'b1,1'b0,2'd3,1'b0,32'h104, 32'h0,       32'hCAFEF00D,1'b0,1'b0,4'hF,32'h0,       32'h104, 32'hCAFEF00D};
    v[13] = '{1'b0,1'b1,2'd0,1'b0,32'h5,   32'hABCDEF77,32'h0,       1'b0,1'b0,4'h2,32'h77777777,32'h4,   32'hCAFEF00D};
    v[14] = '{1'b1,1'b0,2'd1,1'b0,32'h2,   32'h0,       32'h80010000,1'b0,1'b0,4'hC,32'h0,       32'h0,   32'hFFFF8001};
    v[15] = '{1'b0,1'b1,2'd2,1'b0,32'h7F00,32'h11223344,32'h0,       1'b0,1'b0,4'hF,32'h11223344,32'h7F00,32'hFFFF8001};
    @(negedge clk); #1;
    chk("rst_req", {31'h0, bus_req}, 32'h0);
    chk("rst_we", {31'h0, bus_we}, 32'h0);
    chk("rst_be", {28'h0, bus_be}, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_dmrd", M_DMRD, 32'h0);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(v[i].ld, v[i].st, v[i].sz, v[i].uns, v[i].addr, v[i].wdata);
      bus_ack = 1'b0; Req = 1'b0; bus_rdata = v[i].rdata;
      #1;
      chk($sformatf("v%0d_adel", i), {31'h0, exc_adel}, {31'h0, v[i].adel});
      chk($sformatf("v%0d_ades", i), {31'h0, exc_ades}, {31'h0, v[i].ades});
      chk($sformatf("v%0d_stall0", i), {31'h0, mem_stall}, {31'h0, ~(v[i].adel | v[i].ades)});
      if (v[i].adel | v[i].ades) begin
        @(negedge clk); #1;
        chk($sformatf("v%0d_exc_req", i), {31'h0, bus_req}, 32'h0);
        chk($sformatf("v%0d_exc_dmrd", i), M_DMRD, v[i].dmrd);
        idle_in();
      end else begin
        @(negedge clk); #1;
        chk($sformatf("v%0d_req", i), {31'h0, bus_req}, 32'h1);
        chk($sformatf("v%0d_we", i), {31'h0, bus_we}, {31'h0, v[i].st});
        chk($sformatf("v%0d_be", i), {28'h0, bus_be}, {28'h0, v[i].be});
        chk($sformatf("v%0d_addr", i), bus_addr, v[i].baddr);
        chk($sformatf("v%0d_wdata", i), bus_wdata, v[i].bwd);
        bus_ack = 1'b1;
        @(negedge clk); bus_ack = 1'b0; #1;
        chk($sformatf("v%0d_done_req", i), {31'h0, bus_req}, 32'h0);
        chk($sformatf("v%0d_done_stall", i), {31'h0, mem_stall}, 32'h0);
        chk($sformatf("v%0d_dmrd", i), M_DMRD, v[i].dmrd);
        @(negedge clk); #1;
        chk($sformatf("v%0d_norestart", i), {31'h0, bus_req}, 32'h0);
        idle_in();
      end
    end
    // lw with two wait cycles: four stall cycles then DONE
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0); bus_rdata = 32'hDEADBEEF; cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      bus_ack = (c == 3);
      #1;
      if (mem_stall) cnt++; else break;
    end
    chk("wait2_stall_cycles", cnt, 4);
    chk("wait2_dmrd", M_DMRD, 32'hDEADBEEF);
    chk("wait2_req", {31'h0, bus_req}, 32'h0);
    bus_ack = 1'b0;
    @(negedge clk); idle_in();
    // Req and ack together in WAIT: back to IDLE, result discarded
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0); bus_rdata = 32'h11111111;
    @(negedge clk); bus_ack = 1'b1; Req = 1'b1; #1;
    chk("flushack_stall", {31'h0, mem_stall}, 32'h1);
    @(negedge clk); bus_ack = 1'b0; Req = 1'b0; idle_in(); #1;
    chk("flushack_req", {31'h0, bus_req}, 32'h0);
    chk("flushack_dmrd", M_DMRD, 32'hDEADBEEF);
    chk("flushack_stall_after", {31'h0, mem_stall}, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0); Req = 1'b1; #1;
    chk("req_blocks_start", {31'h0, mem_stall}, 32'h0);
    @(negedge clk); #1;
    chk("req_blocks_bus", {31'h0, bus_req}, 32'h0);
    Req = 1'b0; idle_in();
    // Req in WAIT without ack: DRAIN holds the request until the late ack
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0); bus_rdata = 32'h55555555;
    @(negedge clk); Req = 1'b1; #1;
    chk("drain_wait_req", {31'h0, bus_req}, 32'h1);
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      Req = 1'b0; drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h99); bus_ack = (d == 2);
      #1;
      chk($sformatf("drain%0d_req", d), {31'h0, bus_req}, 32'h1);
      chk($sformatf("drain%0d_stall", d), {31'h0, mem_stall}, 32'h1);
      chk($sformatf("drain%0d_addr", d), bus_addr, 32'h20);
      chk($sformatf("drain%0d_we", d), {31'h0, bus_we}, 32'h0);
    end
    @(negedge clk); bus_ack = 1'b0; #1;
    chk("drain_exit_req", {31'h0, bus_req}, 32'h0);
    chk("drain_dmrd", M_DMRD, 32'hDEADBEEF);
    chk("drain_next_stall", {31'h0, mem_stall}, 32'h1);
    @(negedge clk); #1;
    chk("sw_after_req", {31'h0, bus_req}, 32'h1);
    chk("sw_after_we", {31'h0, bus_we}, 32'h1);
    chk("sw_after_addr", bus_addr, 32'h40);
    chk("sw_after_wdata", bus_wdata, 32'h99);
    bus_ack = 1'b1;
    @(negedge clk); bus_ack = 1'b0; #1;
    chk("sw_after_done_stall", {31'h0, mem_stall}, 32'h0);
    chk("sw_after_dmrd", M_DMRD, 32'hDEADBEEF);
    @(negedge clk); idle_in();
    // asynchronous reset during WAIT
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0);
    @(negedge clk); #1;
    chk("arst_pre_req", {31'h0, bus_req}, 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("arst_req", {31'h0, bus_req}, 32'h0);
    chk("arst_be", {28'h0, bus_be}, 32'h0);
    chk("arst_addr", bus_addr, 32'h0);
    chk("arst_dmrd", M_DMRD, 32'h0);
    idle_in();
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h48, 32'h0); bus_rdata = 32'h0BADF00D;
    @(negedge clk); bus_ack = 1'b1;
    @(negedge clk); bus_ack = 1'b0; #1;
    chk("post_rst_dmrd", M_DMRD, 32'h0BADF00D);
    @(negedge clk); idle_in();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/m_dm_ctrl.md
Name: m_dm_ctrl

Overview:
- M-stage data-memory access controller, directly upstream of the M/W pipeline register; produces M_DMRD.
- Turns M-stage load/store control into a request/acknowledge bus transaction toward data RAM and the timer devices.
- Generates byte enables and write-data replication, and sign/zero-extends load data.
- Flags address exceptions (AdEL/AdES) to CP0 and stalls the pipeline while a transaction is outstanding.

Parameters:
- DM_LO, 32'h0000_0000, lowest data-RAM byte address.
- DM_HI, 32'h0000_2FFF, highest data-RAM byte address.
- DEV_LO, 32'h0000_7F00, lowest device byte address.
- DEV_HI, 32'h0000_7F1B, highest device byte address (word access only).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- m_load  in  1  M-stage instruction is a load.
- m_store  in  1  M-stage instruction is a store.
- m_size  in  2  access size: 0 byte, 1 half, 2 word; 3 is reserved and treated as word.
- m_unsigned  in  1  zero-extend the load (lbu/lhu).
- m_addr  in  32  effective byte address.
- m_wdata  in  32  store data, right-aligned.
- Req  in  1  CP0 exception/interrupt flush.
- bus_ack  in  1  memory acknowledge; rdata valid in the same cycle.
- bus_rdata  in  32  memory read word.
- bus_req  out  1  transaction request.
- bus_we  out  1  write strobe.
- bus_be  out  4  byte enables.
- bus_addr  out  32  word-aligned address ({m_addr[31:2],2'b00}).
- bus_wdata  out  32  lane-replicated write data.
- M_DMRD  out  32  extended load result, held until the next completed load.
- mem_stall  out  1  freeze IF..M; bubble into M/W.
- exc_adel  out  1  load address exception (combinational).
- exc_ades  out  1  store address exception (combinational).

Behaviour:
- Reset state: all registered outputs 0 (bus_req, bus_we, bus_be, bus_addr, bus_wdata, M_DMRD); FSM in IDLE.
- start = (m_load|m_store) & ~exc & ~Req.
- An access raises exc when any of these holds:
  - misaligned: word with addr[1:0]!=0, or half with addr[0]!=0;
  - address outside [DM_LO,DM_HI] and outside [DEV_LO,DEV_HI];
  - sub-word access inside the device range.
- exc_adel = m_load & exc. exc_ades = m_store & exc.
- An exception access never touches the bus and never stalls.
- Byte enables:
  - byte: 4'b0001<<addr[1:0];
  - half: 4'b0011<<addr[1:0];
  - word: 4'b1111.
- Write data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as is.
- Load data: bus_rdata>>(8*addr[1:0]), truncated to the access size, then sign- or zero-extended per m_unsigned.
- FSM states: IDLE, WAIT, DONE, DRAIN.
- IDLE:
  - on start, register addr, be, we=m_store, wdata and the load control; bus_req<=1; go to WAIT.
  - otherwise stay in IDLE.
- WAIT:
  - bus_req held high; all bus outputs stable.
  - on bus_ack with Req low: bus_req<=0; if the access is a load, M_DMRD<=extended data; go to DONE.
  - on Req with no bus_ack: go to DRAIN; the transaction is never cut short on the bus.
  - on bus_ack and Req in the same cycle: bus_req<=0, M_DMRD unchanged, go to IDLE.
- DONE: one cycle with mem_stall low so M/W captures the result; always go to IDLE; the still-present m_load/m_store must not restart an access.
- DRAIN:
  - hold bus_req until bus_ack; then bus_req<=0 and go to IDLE; M_DMRD unchanged.
  - a store in DRAIN still commits in memory; this is accepted.
- mem_stall = (IDLE & start) | WAIT | (DRAIN & (m_load|m_store)).
- Minimum occupancy with zero-wait memory (ack in the first bus_req cycle): 3 cycles (IDLE, WAIT, DONE).
- Each extra wait cycle of bus_ack adds one stall cycle.
- Reset asserted mid-transaction: immediate return to IDLE with bus_req low. Memory must tolerate an abandoned request.

Decomposition:
- Shared package def.v holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encodings ST_IDLE/ST_WAIT/ST_DONE/ST_DRAIN;
  - address-map constants matching the parameter defaults.
- One natural sub-module, dm_ext: combinational lane select plus sign/zero extension (rdata, addr[1:0], size, unsigned -> 32-bit result). It is reused by the bus bridge.

Test Plan:
- lw at 0x0000_0010, memory returns 0xDEADBEEF after 2 wait cycles:
  - bus_be=1111, bus_we=0;
  - mem_stall high for 4 cycles, then one DONE cycle;
  - M_DMRD=0xDEADBEEF.
- lb at 0x0000_0013 with rdata 0x80AA_BBCC (byte lane 3 = 0x80): M_DMRD=0xFFFF_FF80. The same access as lbu: M_DMRD=0x0000_0080.
- sh 0x1234 at 0x0000_0022: bus_be=1100, bus_wdata=0x1234_1234, bus_addr=0x0000_0020, bus_we=1.
- lh at 0x0000_0011: exc_adel=1, bus_req stays 0, no stall. sb at 0x0000_7F04: exc_ades=1. sw at 0x0000_5000: exc_ades=1.
- Req pulsed in WAIT of an lw, ack 3 cycles later:
  - FSM passes through DRAIN, bus_req held until ack;
  - M_DMRD keeps its old value;
  - a following sw stalls until DRAIN exits.
- reset low during WAIT: all registered outputs return to 0 and the FSM to IDLE without a clk edge; normal lw succeeds after release.
